// File: rtl/game_pkg.sv
// Shared types and helpers for the game round controller.
// Holds the FSM state encoding, the one-hot level codes and the width helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW,
        INPUT,
        JUDGE,
        GAP,
        DONE
    } state_e;

    localparam logic [2:0] LV1 = 3'b001;
    localparam logic [2:0] LV2 = 3'b010;
    localparam logic [2:0] LV3 = 3'b100;

    // Never returns 0 so that degenerate parameters still give a legal vector.
    function automatic int clog2w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Pattern length for a level code; 0 marks a code that is not one-hot.
    function automatic int level_len(input logic [2:0] lv, input int max_len);
        case (lv)
            LV1:     return max_len / 2;
            LV2:     return 3 * max_len / 4;
            LV3:     return max_len;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/seq_checker.sv
// Walks the player's button presses against the stored pattern.
// full rises once pat_len presses have been taken; mismatch is sticky until clr.
module seq_checker
    import game_pkg::*;
#(
    parameter  int N_BTN   = 8,
    parameter  int MAX_LEN = 16,
    localparam int IW      = clog2w(N_BTN),
    localparam int LW      = clog2w(MAX_LEN + 1)
) (
    input  logic                  clk_1,
    input  logic                  rst,
    input  logic [MAX_LEN*IW-1:0] pattern_flat,
    input  logic [LW-1:0]         pat_len,
    input  logic                  btn_valid,
    input  logic [IW-1:0]         btn_idx,
    input  logic                  clr,
    output logic                  full,
    output logic                  mismatch
);

    logic [LW-1:0] ptr;
    logic [IW-1:0] expected;

    assign expected = pattern_flat[ptr*IW +: IW];
    assign full     = (ptr == pat_len);

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            mismatch <= 1'b0;
        end else if (clr) begin
            ptr      <= '0;
            mismatch <= 1'b0;
        end else if (btn_valid && !full) begin
            // Presses past the end are dropped so the pointer never leaves the pattern.
            ptr      <= ptr + 1'b1;
            mismatch <= mismatch | (btn_idx != expected);
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for a memory game: request pattern, play it back, collect and judge presses.
// Define ROUND_TIMEOUT_EN to lose a round after TIMEOUT_CYC cycles without a press.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter  int N_BTN       = 8,
    parameter  int MAX_LEN     = 16,
    parameter  int N_ROUNDS    = 10,
    parameter  int PTS_PER_WIN = 10,
    parameter  int GAP_CYC     = 4,
    parameter  int TIMEOUT_CYC = 1000000,
    localparam int IW          = clog2w(N_BTN),
    localparam int LW          = clog2w(MAX_LEN + 1),
    localparam int RW          = clog2w(N_ROUNDS + 1),
    localparam int SW          = clog2w(N_ROUNDS * PTS_PER_WIN + 1)
) (
    input  logic                  clk_1,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            level,
    output logic                  gen_req,
    input  logic                  gen_done,
    input  logic [MAX_LEN*IW-1:0] pattern_flat,
    output logic                  show_req,
    input  logic                  show_done,
    output logic [LW-1:0]         pat_len,
    input  logic                  btn_valid,
    input  logic [IW-1:0]         btn_idx,
    output logic [RW-1:0]         round_cnt,
    output logic [RW-1:0]         win_cnt,
    output logic [SW-1:0]         score,
    output logic                  busy,
    output logic                  game_over
);

    localparam int GW = clog2w(GAP_CYC);

    if (MAX_LEN % 4 != 0 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("game_round_ctrl: MAX_LEN must be a multiple of 4, GAP_CYC and TIMEOUT_CYC at least 1");
    end

    // NOTE: reset asserts asynchronously but releases through two flops, so every
    // state register leaves reset on the same clock edge.
    logic rst_meta, rst_sync;

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    state_e        state;
    logic [GW-1:0] gap_cnt;
    logic          full, mismatch, clr, btn_en, start_ok, lost;
    logic [LW-1:0] len_sel;
    int            len_int;

    assign len_int   = level_len(level, MAX_LEN);
    assign start_ok  = start && (len_int != 0);
    assign len_sel   = LW'(len_int);
    assign clr       = (state == SHOW) && show_done;
    assign btn_en    = (state == INPUT) && btn_valid;
    assign busy      = (state != IDLE) && (state != DONE);
    assign game_over = (state == DONE);

    seq_checker #(
        .N_BTN   (N_BTN),
        .MAX_LEN (MAX_LEN)
    ) u_seq_checker (
        .clk_1        (clk_1),
        .rst          (rst_sync),
        .pattern_flat (pattern_flat),
        .pat_len      (pat_len),
        .btn_valid    (btn_en),
        .btn_idx      (btn_idx),
        .clr          (clr),
        .full         (full),
        .mismatch     (mismatch)
    );

`ifdef ROUND_TIMEOUT_EN
    localparam int TW = clog2w(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;
    logic          timed_out;
    assign lost = mismatch || timed_out;
`else
    assign lost = mismatch;
`endif

    // NOTE: non-blocking assignments throughout, so every branch below reads the
    // values held before the edge and the one-cycle pulses default low each cycle.
    always_ff @(posedge clk_1 or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= IDLE;
            pat_len   <= '0;
            round_cnt <= '0;
            win_cnt   <= '0;
            score     <= '0;
            gen_req   <= 1'b0;
            show_req  <= 1'b0;
            gap_cnt   <= '0;
`ifdef ROUND_TIMEOUT_EN
            idle_cnt  <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            gen_req  <= 1'b0;
            show_req <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        pat_len   <= len_sel;
                        round_cnt <= '0;
                        win_cnt   <= '0;
                        score     <= '0;
                        gen_req   <= 1'b1;
                        state     <= GEN;
                    end
                end
                GEN: begin
                    if (gen_done) begin
                        show_req <= 1'b1;
                        state    <= SHOW;
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        state <= INPUT;
`ifdef ROUND_TIMEOUT_EN
                        idle_cnt  <= '0;
                        timed_out <= 1'b0;
`endif
                    end
                end
                INPUT: begin
                    if (full) begin
                        state <= JUDGE;
                    end
`ifdef ROUND_TIMEOUT_EN
                    else if (!btn_valid && idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        timed_out <= 1'b1;
                        state     <= JUDGE;
                    end
                    idle_cnt <= btn_valid ? '0 : idle_cnt + 1'b1;
`endif
                end
                JUDGE: begin
                    round_cnt <= round_cnt + 1'b1;
                    if (!lost) begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                    gap_cnt <= '0;
                    if (round_cnt == RW'(N_ROUNDS - 1)) begin
                        score <= SW'((int'(win_cnt) + int'(!lost)) * PTS_PER_WIN);
                        state <= DONE;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        gen_req <= 1'b1;
                        state   <= GEN;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
